uart_event_assembler: RTL and testbench
=======================================

# uart_event_assembler

Converts the raw UART byte stream from the host replay path into 32-bit EVT 2.0 CD words for the input event FIFO. Frames 5-byte packets, timestamps them, range-checks coordinates, resynchronises on inter-byte gaps, and presents words on a valid/ready interface toward the FIFO write port. It sits between `uart_rx` and `input_fifo`.

## Interface
- `CLK_FREQ_HZ`, 12_000_000, system clock frequency
- `BAUD_RATE`, 115200, UART bit rate; one byte time = 10*CLK_FREQ_HZ/BAUD_RATE cycles
- `TIMEOUT_BYTES`, 4, idle byte-times inside a packet before resync
- `SENSOR_DIM`, 320, coordinates must be < SENSOR_DIM
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `byte_data`  in  8  received byte from `uart_rx`
- `byte_valid`  in  1  one-cycle strobe, byte_data valid
- `ts_lsb`  in  6  low bits of global timestamp
- `evt_data`  out  32  assembled EVT word
- `evt_valid`  out  1  evt_data valid
- `evt_ready`  in  1  downstream accepts (FIFO not full)
- `drop_count`  out  16  packets dropped (range, format, overflow), saturating
- `resync_count`  out  16  timeout resyncs, saturating

## Operation
- Packet byte order: X_HI, X_LO, Y_HI, Y_LO, POL. x = {X_HI[2:0], X_LO}, y = {Y_HI[2:0], Y_LO} (11 bits each).
- FSM states: B0, B1, B2, B3, B4. Each accepted byte advances; byte in B4 completes packet, returns to B0.
- On completion: word = {POL[0] ? 4'h1 : 4'h0, ts_lsb sampled on POL cycle, x, y}.
- Drop (no output, drop_count +1) if x >= SENSOR_DIM, y >= SENSOR_DIM, X_HI[7:3]/Y_HI[7:3] nonzero, or POL[7:1] nonzero.
- Output register single-entry: if evt_valid=1 and not accepted in the completion cycle, new packet is dropped (overflow, drop_count +1); held word unchanged.
- Completion in same cycle as handshake (evt_valid & evt_ready): held word retires, new word loads, evt_valid stays 1.
- Timeout counter: cleared on each byte_valid; counts while state != B0; at TIMEOUT_BYTES*byte-time cycles returns to B0, resync_count +1, partial bytes discarded. byte_valid in the expiry cycle wins: byte accepted in current state, no resync.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: evt_data=0, evt_valid=0, drop_count=0, resync_count=0, state B0, timeout counter 0.
- Latency: evt_valid rises the cycle after the POL byte strobe.
- evt_valid holds with stable evt_data until evt_ready sampled high; deasserts next cycle unless replaced.
- Mid-packet reset: partial packet discarded, state B0, held word lost.
- evt_ready has no combinational path to evt_valid or evt_data.

## Structure
- Shared package `evt2_pkg`: EVT type codes (CD_OFF=4'h0, CD_ON=4'h1), word field widths/offsets, packet byte count (5), FSM enum.
- Single module; saturating counter logic inline. No sub-module.

## Test plan
- Bytes 00,64,00,32,01 with ts_lsb=6'h15, evt_ready=1 -> one word {4'h1,6'h15,11'd100,11'd50}, evt_valid one cycle.
- Bytes 01,40,00,10,00 (x=320) -> no output, drop_count=1.
- Two back-to-back packets with evt_ready=0 -> first word held, drop_count=1; evt_ready=1 -> first word retires.
- Bytes 00,64 then idle 4 byte-times+1 cycle -> resync_count=1; following valid 5-byte packet decodes correctly.
- Byte_valid exactly on timeout expiry cycle -> no resync, packet continues.
- Assert rst after 3 bytes -> outputs zero; next 5-byte packet decodes from B0.

Source files
------------

// File: rtl/evt2_pkg.sv
// evt2_pkg: shared EVT 2.0 definitions for the input event path.
// Holds the CD event type codes, the bit layout of the 32-bit EVT word,
// the replay packet length and the packet-framing FSM state type.
package evt2_pkg;

  // CD event type codes (top nibble of the EVT word)
  localparam logic [3:0] CD_OFF = 4'h0;
  localparam logic [3:0] CD_ON  = 4'h1;

  // EVT word field widths and bit offsets:
  // [31:28] type, [27:22] timestamp LSBs, [21:11] x, [10:0] y
  localparam int WORD_W   = 32;
  localparam int TYPE_W   = 4;
  localparam int TS_W     = 6;
  localparam int COORD_W  = 11;
  localparam int Y_LSB    = 0;
  localparam int X_LSB    = Y_LSB + COORD_W;
  localparam int TS_LSB   = X_LSB + COORD_W;
  localparam int TYPE_LSB = TS_LSB + TS_W;

  // Bytes per replay packet: X_HI, X_LO, Y_HI, Y_LO, POL
  localparam int PKT_BYTES = 5;

  // Framing state = index of the next expected byte within the packet
  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    B3 = 3'd3,
    B4 = 3'd4
  } pkt_state_e;

endpackage

// File: rtl/uart_event_assembler.sv
// uart_event_assembler: frames the UART replay byte stream into 5-byte
// packets and turns each good packet into one 32-bit EVT 2.0 CD word.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   byte_data      received byte from uart_rx
//   byte_valid     one-cycle strobe qualifying byte_data
//   ts_lsb         low bits of the global timestamp, sampled on the POL byte
//   evt_data       assembled EVT word (held while evt_valid is high)
//   evt_valid      evt_data valid toward the event FIFO
//   evt_ready      FIFO can accept
//   drop_count     saturating count of packets dropped (range/format/overflow)
//   resync_count   saturating count of inter-byte timeout resyncs
//
// Handshake: a word transfers on any cycle with evt_valid & evt_ready high.
// evt_valid/evt_data are registers and stay stable until that transfer; a
// packet completing in the transfer cycle replaces the word without a bubble.
// evt_ready only feeds register inputs, never the outputs directly.
module uart_event_assembler
  import evt2_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 12_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int TIMEOUT_BYTES = 4,
  parameter int SENSOR_DIM    = 320
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          byte_data,
  input  logic                byte_valid,
  input  logic [TS_W-1:0]     ts_lsb,
  output logic [WORD_W-1:0]   evt_data,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [15:0]         drop_count,
  output logic [15:0]         resync_count
);

  localparam int BYTE_CYCLES    = 10 * CLK_FREQ_HZ / BAUD_RATE;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * BYTE_CYCLES;
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COORD_W-1:0] DIM     = COORD_W'(SENSOR_DIM);

  pkt_state_e       state_q, state_d;
  logic [7:0]       x_hi_q, x_lo_q, y_hi_q, y_lo_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             timeout_hit;

  logic [COORD_W-1:0] pkt_x, pkt_y;
  logic               pkt_done, fmt_bad, range_bad, load, drop_inc;
  logic [WORD_W-1:0]  pkt_word;

  // Next-state: every byte advances, POL byte wraps to B0. With no byte,
  // a partial packet that has idled for the full timeout falls back to B0.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    if (byte_valid) begin
      case (state_q)
        B0:      state_d = B1;
        B1:      state_d = B2;
        B2:      state_d = B3;
        B3:      state_d = B4;
        B4:      state_d = B0;
        default: state_d = B0;
      endcase
    end else if (state_q != B0 && to_cnt_q == TO_LAST) begin
      state_d     = B0;
      timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= B0;
    else     state_q <= state_d;
  end

  // Packet decode; the POL byte is consumed directly from byte_data
  assign pkt_x     = {x_hi_q[2:0], x_lo_q};
  assign pkt_y     = {y_hi_q[2:0], y_lo_q};
  assign pkt_done  = byte_valid && (state_q == B4);
  assign fmt_bad   = (x_hi_q[7:3] != 5'd0) || (y_hi_q[7:3] != 5'd0) ||
                     (byte_data[7:1] != 7'd0);
  assign range_bad = (pkt_x >= DIM) || (pkt_y >= DIM);
  assign pkt_word  = {(byte_data[0] ? CD_ON : CD_OFF), ts_lsb, pkt_x, pkt_y};

  // A good packet loads only if the output slot is empty or retiring now;
  // otherwise it is an overflow and the held word is kept.
  assign load     = pkt_done && !fmt_bad && !range_bad && (!evt_valid || evt_ready);
  assign drop_inc = pkt_done && !load;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_hi_q       <= '0;
      x_lo_q       <= '0;
      y_hi_q       <= '0;
      y_lo_q       <= '0;
      to_cnt_q     <= '0;
      evt_data     <= '0;
      evt_valid    <= 1'b0;
      drop_count   <= '0;
      resync_count <= '0;
    end else begin
      if (byte_valid) begin
        case (state_q)
          B0:      x_hi_q <= byte_data;
          B1:      x_lo_q <= byte_data;
          B2:      y_hi_q <= byte_data;
          B3:      y_lo_q <= byte_data;
          default: ;
        endcase
      end

      // Idle counter only runs inside a packet; any byte restarts it
      if (byte_valid || timeout_hit || state_q == B0) to_cnt_q <= '0;
      else                                             to_cnt_q <= to_cnt_q + TO_W'(1);

      if (load) begin
        evt_data  <= pkt_word;
        evt_valid <= 1'b1;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end

      if (drop_inc && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
      if (timeout_hit && resync_count != 16'hFFFF)
        resync_count <= resync_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_event_assembler.sv
// tb_uart_event_assembler: directed bench for uart_event_assembler.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_event_assembler;

  // 4 byte-times at 12 MHz / 115200 baud: 4 * floor(120e6/115200) = 4 * 1041
  localparam int TIMEOUT_CYCLES = 4164;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [5:0]  ts_lsb;
  logic [31:0] evt_data;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] drop_count;
  logic [15:0] resync_count;

  int tests_run  = 0;
  int tests_fail = 0;

  uart_event_assembler dut (
    .clk          (clk),
    .rst          (rst),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .ts_lsb       (ts_lsb),
    .evt_data     (evt_data),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .drop_count   (drop_count),
    .resync_count (resync_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: called at a falling edge, return at a falling edge
  task automatic send_byte(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] b0, b1, b2, b3, b4);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    byte_data = 8'h00; byte_valid = 1'b0; ts_lsb = 6'h00; evt_ready = 1'b1;
    @(negedge clk);
    do_reset();
    tests_run++;
    if (evt_data !== 32'h0) begin tests_fail++; $display("FAIL reset_data got %h exp %h", evt_data, 32'h0); end
    tests_run++;
    if (evt_valid !== 1'b0) begin tests_fail++; $display("FAIL reset_valid got %b exp 0", evt_valid); end
    tests_run++;
    if (drop_count !== 16'd0) begin tests_fail++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
    tests_run++;
    if (resync_count !== 16'd0) begin tests_fail++; $display("FAIL reset_resync got %0d exp 0", resync_count); end
  endtask

  task automatic test_basic();
    evt_ready = 1'b1;
    ts_lsb    = 6'h15;
    send_byte(8'h00); send_byte(8'h64); send_byte(8'h00); send_byte(8'h32);
    tests_run++;
    if (evt_valid !== 1'b0) begin tests_fail++; $display("FAIL basic_early_valid got %b exp 0", evt_valid); end
    send_byte(8'h01);
    tests_run++;
    if (evt_valid !== 1'b1) begin tests_fail++; $display("FAIL basic_valid got %b exp 1", evt_valid); end
    tests_run++;
    if (evt_data !== {4'h1, 6'h15, 11'd100, 11'd50}) begin
      tests_fail++; $display("FAIL basic_data got %h exp %h", evt_data, {4'h1, 6'h15, 11'd100, 11'd50});
    end
    @(negedge clk);
    tests_run++;
    if (evt_valid !== 1'b0) begin tests_fail++; $display("FAIL basic_one_cycle got %b exp 0", evt_valid); end
  endtask

  task automatic test_drops();
    evt_ready = 1'b1;
    ts_lsb    = 6'h2A;
    send_pkt(8'h01, 8'h40, 8'h00, 8'h10, 8'h00);   // x = 320
    tests_run++;
    if (evt_valid !== 1'b0 || drop_count !== 16'd1) begin
      tests_fail++; $display("FAIL drop_x_range got valid=%b drop=%0d exp valid=0 drop=1", evt_valid, drop_count);
    end
    send_pkt(8'h00, 8'h00, 8'h01, 8'h40, 8'h01);   // y = 320
    send_pkt(8'h08, 8'h00, 8'h00, 8'h00, 8'h00);   // X_HI[3] set
    send_pkt(8'h00, 8'h00, 8'h00, 8'h00, 8'h02);   // POL[1] set
    tests_run++;
    if (evt_valid !== 1'b0 || drop_count !== 16'd4) begin
      tests_fail++; $display("FAIL drop_format got valid=%b drop=%0d exp valid=0 drop=4", evt_valid, drop_count);
    end
    send_pkt(8'h01, 8'h3F, 8'h01, 8'h3F, 8'h00);   // x = y = 319, OFF
    tests_run++;
    if (evt_valid !== 1'b1 || evt_data !== {4'h0, 6'h2A, 11'd319, 11'd319}) begin
      tests_fail++; $display("FAIL edge_319 got valid=%b data=%h exp valid=1 data=%h",
                             evt_valid, evt_data, {4'h0, 6'h2A, 11'd319, 11'd319});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    evt_ready = 1'b0;
    ts_lsb    = 6'h0A;
    send_pkt(8'h00, 8'h05, 8'h00, 8'h06, 8'h01);
    ts_lsb    = 6'h0B;
    send_pkt(8'h00, 8'h07, 8'h00, 8'h08, 8'h00);
    idle(3);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_data !== {4'h1, 6'h0A, 11'd5, 11'd6} || drop_count !== 16'd5) begin
      tests_fail++; $display("FAIL overflow_hold got valid=%b data=%h drop=%0d exp valid=1 data=%h drop=5",
                             evt_valid, evt_data, drop_count, {4'h1, 6'h0A, 11'd5, 11'd6});
    end
    evt_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (evt_valid !== 1'b0) begin tests_fail++; $display("FAIL overflow_retire got %b exp 0", evt_valid); end

    // completion in the same cycle as the handshake replaces the word
    evt_ready = 1'b0;
    ts_lsb    = 6'h11;
    send_pkt(8'h00, 8'h01, 8'h00, 8'h02, 8'h00);
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h00); send_byte(8'h04);
    ts_lsb    = 6'h12;
    evt_ready = 1'b1;
    send_byte(8'h01);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_data !== {4'h1, 6'h12, 11'd3, 11'd4} || drop_count !== 16'd5) begin
      tests_fail++; $display("FAIL swap got valid=%b data=%h drop=%0d exp valid=1 data=%h drop=5",
                             evt_valid, evt_data, drop_count, {4'h1, 6'h12, 11'd3, 11'd4});
    end
    @(negedge clk);
    tests_run++;
    if (evt_valid !== 1'b0) begin tests_fail++; $display("FAIL swap_retire got %b exp 0", evt_valid); end
  endtask

  task automatic test_timeout();
    evt_ready = 1'b1;
    ts_lsb    = 6'h20;
    send_byte(8'h00); send_byte(8'h64);
    idle(TIMEOUT_CYCLES - 1);
    tests_run++;
    if (resync_count !== 16'd0) begin tests_fail++; $display("FAIL timeout_early got %0d exp 0", resync_count); end
    idle(1);
    tests_run++;
    if (resync_count !== 16'd1) begin tests_fail++; $display("FAIL timeout_fire got %0d exp 1", resync_count); end
    idle(2);
    send_pkt(8'h00, 8'h0C, 8'h00, 8'h22, 8'h01);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_data !== {4'h1, 6'h20, 11'd12, 11'd34}) begin
      tests_fail++; $display("FAIL timeout_recover got valid=%b data=%h exp valid=1 data=%h",
                             evt_valid, evt_data, {4'h1, 6'h20, 11'd12, 11'd34});
    end
    @(negedge clk);
  endtask

  task automatic test_expiry_byte();
    evt_ready = 1'b1;
    ts_lsb    = 6'h3F;
    send_byte(8'h00);
    idle(TIMEOUT_CYCLES - 1);
    send_byte(8'h2D);          // lands on the expiry cycle
    send_byte(8'h00); send_byte(8'h2E); send_byte(8'h00);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_data !== {4'h0, 6'h3F, 11'd45, 11'd46} || resync_count !== 16'd1) begin
      tests_fail++; $display("FAIL expiry_byte got valid=%b data=%h resync=%0d exp valid=1 data=%h resync=1",
                             evt_valid, evt_data, resync_count, {4'h0, 6'h3F, 11'd45, 11'd46});
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    evt_ready = 1'b0;
    ts_lsb    = 6'h05;
    send_pkt(8'h00, 8'h09, 8'h00, 8'h09, 8'h01);   // held word
    send_byte(8'h00); send_byte(8'h64); send_byte(8'h00);
    do_reset();
    tests_run++;
    if (evt_valid !== 1'b0 || evt_data !== 32'h0 || drop_count !== 16'd0 || resync_count !== 16'd0) begin
      tests_fail++; $display("FAIL midreset_zero got valid=%b data=%h drop=%0d resync=%0d exp all 0",
                             evt_valid, evt_data, drop_count, resync_count);
    end
    evt_ready = 1'b1;
    ts_lsb    = 6'h07;
    send_pkt(8'h00, 8'h10, 8'h00, 8'h20, 8'h01);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_data !== {4'h1, 6'h07, 11'd16, 11'd32}) begin
      tests_fail++; $display("FAIL midreset_decode got valid=%b data=%h exp valid=1 data=%h",
                             evt_valid, evt_data, {4'h1, 6'h07, 11'd16, 11'd32});
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_drops();
    test_back_to_back();
    test_timeout();
    test_expiry_byte();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
